// File: rtl/stop_watch_lap.sv
// Parametrised BCD stopwatch/countdown timer with preset load, lap freeze,
// sticky up-mode overflow and sticky down-mode done flags.
module stop_watch_lap #(
  parameter int DVSR  = 10000000,
  parameter int N_DIG = 3,
  parameter int W     = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               clr,
  input  logic               up,
  input  logic               load,
  input  logic [4*N_DIG-1:0] din,
  input  logic               lap,
  output logic [4*N_DIG-1:0] dout,
  output logic               ovf,
  output logic               done,
  output logic               frozen
);

  localparam logic [W-1:0] LAST = W'(DVSR - 1);

  typedef logic [N_DIG-1:0][3:0] digs_t;

  logic [W-1:0] cnt, cnt_nxt;
  digs_t        dig, dig_nxt, lap_val, din_clamp, dig_inc, dig_dec;
  logic         run, tick, all9, all0, carry, borrow, ovf_nxt, done_nxt;

  assign run  = go && !done;
  assign tick = run && (cnt == LAST);

  // Ripple carry/borrow chains; after the loop they hold "all nines"/"all zeros".
  always_comb begin
    carry     = 1'b1;
    borrow    = 1'b1;
    din_clamp = '0;
    dig_inc   = dig;
    dig_dec   = dig;
    for (int i = 0; i < N_DIG; i++) begin
      din_clamp[i] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
      if (carry)
        dig_inc[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
      if (borrow)
        dig_dec[i] = (dig[i] == 4'd0) ? 4'd9 : dig[i] - 4'd1;
      carry  = carry && (dig[i] == 4'd9);
      borrow = borrow && (dig[i] == 4'd0);
    end
    all9 = carry;
    all0 = borrow;
  end

  always_comb begin
    cnt_nxt  = cnt;
    dig_nxt  = dig;
    ovf_nxt  = ovf;
    done_nxt = done;
    if (load) begin
      dig_nxt  = din_clamp;
      cnt_nxt  = '0;
      ovf_nxt  = 1'b0;
      done_nxt = 1'b0;
    end else begin
      if (run)
        cnt_nxt = tick ? '0 : cnt + 1'b1;
      if (tick) begin
        if (up) begin
          dig_nxt = dig_inc;
          if (all9)
            ovf_nxt = 1'b1;
        end else if (all0) begin
          done_nxt = 1'b1;
        end else begin
          dig_nxt = dig_dec;
        end
      end
    end
  end

  // A lap capture takes the value being written this edge, so load+lap latches the preset.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt     <= '0;
      dig     <= '0;
      lap_val <= '0;
      frozen  <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      dig  <= dig_nxt;
      ovf  <= ovf_nxt;
      done <= done_nxt;
      if (lap) begin
        if (!frozen)
          lap_val <= dig_nxt;
        frozen <= !frozen;
      end
    end
  end

  assign dout = frozen ? lap_val : dig;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Directed self-checking bench for stop_watch_lap with DVSR=4, N_DIG=3.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_stop_watch_lap;

  logic        clk = 1'b0;
  logic        reset, go, clr, up, load, lap;
  logic [11:0] din;
  logic [11:0] dout;
  logic        ovf, done, frozen;
  logic [14:0] obs, exp;

  int vectors    = 0;
  int miscompares = 0;

  stop_watch_lap #(.DVSR(4), .N_DIG(3), .W(4)) dut (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .load(load),
    .din(din), .lap(lap), .dout(dout), .ovf(ovf), .done(done), .frozen(frozen)
  );

  always #5 clk = ~clk;

  // Observed word: {dout, ovf, done, frozen}
  assign obs = {dout, ovf, done, frozen};

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; lap = 1'b0; din = 12'h000;
    cycles(2);
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL reset got %h want %h", obs, exp); end
  endtask

  task automatic test_count_up;
    reset = 1'b0;
    cycles(3);
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL up_before_first_tick got %h want %h", obs, exp); end
    cycles(1);
    exp = {12'h001, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL up_first_tick got %h want %h", obs, exp); end
    for (int k = 2; k <= 10; k++) begin
      cycles(4);
      exp = {4'h0, 4'(k / 10), 4'(k % 10), 3'b000}; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL up_count_%0d got %h want %h", k, obs, exp); end
    end
  endtask

  task automatic test_overflow;
    din = 12'h998; load = 1'b1;
    cycles(1);
    load = 1'b0;
    exp = {12'h998, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL ovf_load got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h999, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL ovf_999 got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h000, 3'b100}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL ovf_wrap got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h001, 3'b100}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL ovf_sticky got %h want %h", obs, exp); end
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL ovf_clr got %h want %h", obs, exp); end
    din = 12'h099; load = 1'b1;
    cycles(1);
    load = 1'b0;
    cycles(4);
    exp = {12'h100, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL up_carry_two got %h want %h", obs, exp); end
  endtask

  task automatic test_countdown;
    up = 1'b0; din = 12'h002; load = 1'b1;
    cycles(1);
    load = 1'b0;
    exp = {12'h002, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_load got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h001, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_001 got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_reach_zero got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h000, 3'b010}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_done got %h want %h", obs, exp); end
    // With done set the prescaler is stopped, so even up mode must not advance.
    up = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycles(4);
      exp = {12'h000, 3'b010}; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_halted_%0d got %h want %h", k, obs, exp); end
    end
    up = 1'b0; din = 12'h100; load = 1'b1;
    cycles(1);
    load = 1'b0;
    exp = {12'h100, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_load_clears_done got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h099, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL down_borrow_two got %h want %h", obs, exp); end
  endtask

  task automatic test_lap;
    up = 1'b1; clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    cycles(20);
    exp = {12'h005, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL lap_pre got %h want %h", obs, exp); end
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    exp = {12'h005, 3'b001}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL lap_freeze got %h want %h", obs, exp); end
    for (int k = 1; k < 8; k++) begin
      cycles(1);
      exp = {12'h005, 3'b001}; vectors++;
      if (obs !== exp) begin miscompares++; $display("[TB] FAIL lap_hold_%0d got %h want %h", k, obs, exp); end
    end
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    exp = {12'h007, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL lap_release got %h want %h", obs, exp); end
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    exp = {12'h007, 3'b001}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL lap_refreeze got %h want %h", obs, exp); end
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL lap_clr_frozen got %h want %h", obs, exp); end
  endtask

  task automatic test_go_pause;
    cycles(2);
    go = 1'b0;
    cycles(3);
    go = 1'b1;
    cycles(1);
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL pause_no_early_tick got %h want %h", obs, exp); end
    cycles(1);
    exp = {12'h001, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL pause_delayed_tick got %h want %h", obs, exp); end
    cycles(3);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL clr_in_tick got %h want %h", obs, exp); end
    cycles(3);
    exp = {12'h000, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL clr_cnt_zero got %h want %h", obs, exp); end
    cycles(1);
    exp = {12'h001, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL clr_next_tick got %h want %h", obs, exp); end
  endtask

  task automatic test_load;
    din = 12'hA3F; load = 1'b1;
    cycles(1);
    load = 1'b0;
    exp = {12'h939, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_clamp got %h want %h", obs, exp); end
    cycles(3);
    din = 12'h123; load = 1'b1;
    cycles(1);
    load = 1'b0;
    exp = {12'h123, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_beats_tick got %h want %h", obs, exp); end
    cycles(3);
    exp = {12'h123, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_cnt_reset got %h want %h", obs, exp); end
    cycles(1);
    exp = {12'h124, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_then_tick got %h want %h", obs, exp); end
    din = 12'h456; load = 1'b1; lap = 1'b1;
    cycles(1);
    load = 1'b0; lap = 1'b0;
    exp = {12'h456, 3'b001}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_with_lap got %h want %h", obs, exp); end
    cycles(4);
    exp = {12'h456, 3'b001}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_lap_hold got %h want %h", obs, exp); end
    din = 12'h111; load = 1'b1;
    cycles(1);
    load = 1'b0;
    exp = {12'h456, 3'b001}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_keeps_frozen got %h want %h", obs, exp); end
    lap = 1'b1;
    cycles(1);
    lap = 1'b0;
    exp = {12'h111, 3'b000}; vectors++;
    if (obs !== exp) begin miscompares++; $display("[TB] FAIL load_unfreeze got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_overflow();
    test_countdown();
    test_lap();
    test_go_pause();
    test_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
